// File: rtl/mcu_global_run_scheduler.sv
// Global run scheduler for NUM_LOCAL read-only BRAM local FSMs.
// Latches a run configuration, broadcasts the shared state bus and counter maxima,
// waits for every local to report its last beat, and aggregates error sources.
// Optional feature macro: MCU_GLO_TIMEOUT_EN adds an OPE-phase watchdog
// (input timeout_limit_i, extra err_src_o bit NUM_LOCAL+2).
module mcu_global_run_scheduler #(
  parameter int unsigned NUM_LOCAL        = 4,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned INTER_ITER_WIDTH = 32,
  parameter int unsigned INTRA_ITER_WIDTH = 32,
  parameter int unsigned CYC_CNT_WIDTH    = 32,
  parameter int unsigned GLO_FSM_WIDTH    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_start_i,
  input  logic                        cfg_abort_i,
  input  logic                        cfg_err_clr_i,
  input  logic [ADDR_WIDTH:0]         cfg_addr_max_i,
  input  logic [INTER_ITER_WIDTH-1:0] cfg_inter_max_i,
  input  logic [INTRA_ITER_WIDTH-1:0] cfg_intra_max_i,
`ifdef MCU_GLO_TIMEOUT_EN
  input  logic [CYC_CNT_WIDTH-1:0]    timeout_limit_i,
`endif
  output logic [GLO_FSM_WIDTH-1:0]    glo_fsm_state_o,
  output logic [ADDR_WIDTH:0]         addr_counter_max_o,
  output logic [INTER_ITER_WIDTH-1:0] inter_counter_max_o,
  output logic [INTRA_ITER_WIDTH-1:0] intra_counter_max_o,
  input  logic [NUM_LOCAL-1:0]        loc_tlast_transmitted_i,
  input  logic [NUM_LOCAL-1:0]        loc_error_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
`ifdef MCU_GLO_TIMEOUT_EN
  output logic [NUM_LOCAL+2:0]        err_src_o,
`else
  output logic [NUM_LOCAL+1:0]        err_src_o,
`endif
  output logic [CYC_CNT_WIDTH-1:0]    run_cycles_o
);

`ifdef MCU_GLO_TIMEOUT_EN
  localparam int unsigned ErrW = NUM_LOCAL + 3;
`else
  localparam int unsigned ErrW = NUM_LOCAL + 2;
`endif

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StStr  = 3'd1,
    StOpe  = 3'd2,
    StEnd  = 3'd3,
    StErr  = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH:0]         addr_max_q;
  logic [INTER_ITER_WIDTH-1:0] inter_max_q;
  logic [INTRA_ITER_WIDTH-1:0] intra_max_q;
  logic [CYC_CNT_WIDTH-1:0]    run_cycles_q;
  logic [NUM_LOCAL-1:0]        done_mask_q;
  logic [ErrW-1:0]             err_src_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        error_q;
`ifdef MCU_GLO_TIMEOUT_EN
  logic [CYC_CNT_WIDTH-1:0]    timeout_lim_q;
`endif

  logic                        cfg_zero;
  logic [NUM_LOCAL-1:0]        mask_now;
  logic                        timeout_hit;
  logic                        start_ok;
  logic                        start_bad;
  logic                        go_abort;
  logic                        go_timeout;

  assign cfg_zero = (cfg_addr_max_i == '0) || (cfg_inter_max_i == '0) ||
                    (cfg_intra_max_i == '0);
  // Flags arriving this cycle count towards completion immediately.
  assign mask_now = done_mask_q | loc_tlast_transmitted_i;

`ifdef MCU_GLO_TIMEOUT_EN
  // A zero limit disables the watchdog.
  assign timeout_hit = (timeout_lim_q != '0) && (run_cycles_q == timeout_lim_q);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state decode; priority inside OPE is error, abort, completion, timeout.
  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    go_abort   = 1'b0;
    go_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_start_i) begin
          if (cfg_zero) begin
            state_d   = StErr;
            start_bad = 1'b1;
          end else begin
            state_d  = StStr;
            start_ok = 1'b1;
          end
        end
      end
      StStr: state_d = StOpe;
      StOpe: begin
        if (|loc_error_i) begin
          state_d = StErr;
        end else if (cfg_abort_i) begin
          state_d  = StErr;
          go_abort = 1'b1;
        end else if (&mask_now) begin
          state_d = StEnd;
        end else if (timeout_hit) begin
          state_d    = StErr;
          go_timeout = 1'b1;
        end
      end
      StEnd: state_d = StIdle;
      StErr: begin
        // Clear wins over a simultaneous start.
        if (cfg_err_clr_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // All state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_max_q   <= '0;
      inter_max_q  <= '0;
      intra_max_q  <= '0;
      run_cycles_q <= '0;
      done_mask_q  <= '0;
      err_src_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef MCU_GLO_TIMEOUT_EN
      timeout_lim_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == StStr) || (state_d == StOpe) || (state_d == StEnd);
      error_q <= (state_d == StErr);
      done_q  <= (state_q == StEnd);

      if (start_ok) begin
        addr_max_q   <= cfg_addr_max_i;
        inter_max_q  <= cfg_inter_max_i;
        intra_max_q  <= cfg_intra_max_i;
        run_cycles_q <= '0;
        done_mask_q  <= '0;
        err_src_q    <= '0;
`ifdef MCU_GLO_TIMEOUT_EN
        timeout_lim_q <= timeout_limit_i;
`endif
      end

      // A rejected start keeps earlier error sources and only adds its own.
      if (start_bad) err_src_q[NUM_LOCAL+1] <= 1'b1;

      if (state_q == StOpe) begin
        if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + CYC_CNT_WIDTH'(1);
        done_mask_q <= mask_now;
      end

      if ((state_q == StOpe) || (state_q == StErr)) begin
        err_src_q[NUM_LOCAL-1:0] <= err_src_q[NUM_LOCAL-1:0] | loc_error_i;
      end

      if (go_abort) err_src_q[NUM_LOCAL] <= 1'b1;
`ifdef MCU_GLO_TIMEOUT_EN
      if (go_timeout) err_src_q[NUM_LOCAL+2] <= 1'b1;
`endif
    end
  end

`ifndef MCU_GLO_TIMEOUT_EN
  // go_timeout has no effect without the watchdog.
  logic unused_timeout;
  assign unused_timeout = go_timeout;
`endif

  assign glo_fsm_state_o     = GLO_FSM_WIDTH'(state_q);
  assign addr_counter_max_o  = addr_max_q;
  assign inter_counter_max_o = inter_max_q;
  assign intra_counter_max_o = intra_max_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign error_o             = error_q;
  assign err_src_o           = err_src_q;
  assign run_cycles_o        = run_cycles_q;

endmodule

// File: tb/tb_mcu_global_run_scheduler.sv
// Self-checking bench for mcu_global_run_scheduler: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a behavioural model.
module tb_mcu_global_run_scheduler;
  localparam int NL  = 4;
  localparam int AW  = 7;
  localparam int IEW = 6;
  localparam int IAW = 6;
  localparam int CW  = 8;
  localparam int GW  = 3;
  localparam int CycMax = (1 << CW) - 1;
`ifdef MCU_GLO_TIMEOUT_EN
  localparam int ErrW = NL + 3;
`else
  localparam int ErrW = NL + 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0, abort = 1'b0, clr = 1'b0;
  logic [AW:0]    cfg_addr = '0;
  logic [IEW-1:0] cfg_inter = '0;
  logic [IAW-1:0] cfg_intra = '0;
  logic [CW-1:0]  tlimit = '0;
  logic [NL-1:0]  tlast = '0, lerr = '0;
  logic [GW-1:0]  g_state;
  logic [AW:0]    g_addr;
  logic [IEW-1:0] g_inter;
  logic [IAW-1:0] g_intra;
  logic           g_busy, g_done, g_error;
  logic [ErrW-1:0] g_err;
  logic [CW-1:0]  g_cyc;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mcu_global_run_scheduler #(
    .NUM_LOCAL        (NL),
    .ADDR_WIDTH       (AW),
    .INTER_ITER_WIDTH (IEW),
    .INTRA_ITER_WIDTH (IAW),
    .CYC_CNT_WIDTH    (CW),
    .GLO_FSM_WIDTH    (GW)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .cfg_start_i             (start),
    .cfg_abort_i             (abort),
    .cfg_err_clr_i           (clr),
    .cfg_addr_max_i          (cfg_addr),
    .cfg_inter_max_i         (cfg_inter),
    .cfg_intra_max_i         (cfg_intra),
`ifdef MCU_GLO_TIMEOUT_EN
    .timeout_limit_i         (tlimit),
`endif
    .glo_fsm_state_o         (g_state),
    .addr_counter_max_o      (g_addr),
    .inter_counter_max_o     (g_inter),
    .intra_counter_max_o     (g_intra),
    .loc_tlast_transmitted_i (tlast),
    .loc_error_i             (lerr),
    .busy_o                  (g_busy),
    .done_o                  (g_done),
    .error_o                 (g_error),
    .err_src_o               (g_err),
    .run_cycles_o            (g_cyc)
  );

  // Behavioural model: phase 0 idle, 1 start, 2 operate, 3 end, 4 error.
  int              m_state = 0;
  int unsigned     m_addr = 0, m_inter = 0, m_intra = 0, m_cyc = 0, m_tol = 0;
  logic [NL-1:0]   m_mask = '0;
  logic [ErrW-1:0] m_err = '0;
  bit              m_done = 1'b0;

  always @(posedge clk) begin : model
    int          prev;
    int unsigned old_cyc;
    prev = m_state;
    if (rst) begin
      m_state = 0; m_addr = 0; m_inter = 0; m_intra = 0; m_cyc = 0; m_tol = 0;
      m_mask = '0; m_err = '0;
    end else begin
      case (m_state)
        0: if (start) begin
          if (cfg_addr == 0 || cfg_inter == 0 || cfg_intra == 0) begin
            m_err[NL+1] = 1'b1;
            m_state = 4;
          end else begin
            m_addr = cfg_addr; m_inter = cfg_inter; m_intra = cfg_intra;
            m_tol = tlimit; m_cyc = 0; m_mask = '0; m_err = '0;
            m_state = 1;
          end
        end
        1: m_state = 2;
        2: begin
          old_cyc = m_cyc;
          if (m_cyc < CycMax) m_cyc = m_cyc + 1;
          m_mask = m_mask | tlast;
          if (lerr != 0) begin
            m_err[NL-1:0] = m_err[NL-1:0] | lerr;
            m_state = 4;
          end else if (abort) begin
            m_err[NL] = 1'b1;
            m_state = 4;
          end else if (m_mask == {NL{1'b1}}) begin
            m_state = 3;
          end
`ifdef MCU_GLO_TIMEOUT_EN
          else if (m_tol != 0 && old_cyc == m_tol) begin
            m_err[NL+2] = 1'b1;
            m_state = 4;
          end
`endif
        end
        3: m_state = 0;
        4: begin
          m_err[NL-1:0] = m_err[NL-1:0] | lerr;
          if (clr) m_state = 0;
        end
        default: m_state = 0;
      endcase
    end
    m_done = !rst && (prev == 3);
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state", 64'(g_state), 64'(m_state));
      cmp("addr_max", 64'(g_addr), 64'(m_addr));
      cmp("inter_max", 64'(g_inter), 64'(m_inter));
      cmp("intra_max", 64'(g_intra), 64'(m_intra));
      cmp("run_cycles", 64'(g_cyc), 64'(m_cyc));
      cmp("busy", 64'(g_busy), 64'(m_state >= 1 && m_state <= 3));
      cmp("error", 64'(g_error), 64'(m_state == 4));
      cmp("done", 64'(g_done), 64'(m_done));
      cmp("err_src", 64'(g_err), 64'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int a, input int i, input int j);
    cfg_addr = (AW+1)'(a); cfg_inter = IEW'(i); cfg_intra = IAW'(j);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    cmp("reset state", 64'(g_state), 64'd0);
    cmp("reset err_src", 64'(g_err), 64'd0);

    // T1: staggered tlast pulses, last at OPE index 20.
    go(8, 2, 4);
    cmp("T1 str", 64'(g_state), 64'd1);
    tick();
    for (int k = 0; k <= 20; k++) begin
      tlast = {k == 20, k == 12, k == 9, k == 5};
      tick();
    end
    tlast = '0;
    cmp("T1 end state", 64'(g_state), 64'd3);
    cmp("T1 run_cycles", 64'(g_cyc), 64'd21);
    cmp("T1 addr_max", 64'(g_addr), 64'd8);
    tick();
    cmp("T1 done", 64'(g_done), 64'd1);
    cmp("T1 idle", 64'(g_state), 64'd0);
    tick();
    cmp("T1 done drop", 64'(g_done), 64'd0);

    // T2: zero configuration field.
    go(8, 0, 4);
    cmp("T2 err state", 64'(g_state), 64'd4);
    cmp("T2 err_src", 64'(g_err), 64'h20);
    cmp("T2 busy", 64'(g_busy), 64'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    cmp("T2 cleared", 64'(g_state), 64'd0);

    // T3: error and completion together.
    go(4, 1, 1);
    tick();
    lerr = 4'b0100; tlast = 4'hf;
    tick();
    lerr = '0; tlast = '0;
    cmp("T3 err state", 64'(g_state), 64'd4);
    cmp("T3 err_src", 64'(g_err), 64'h4);
    tick();
    cmp("T3 no done", 64'(g_done), 64'd0);
    clr = 1'b1; tick(); clr = 1'b0;

    // T4: abort, start ignored in ERR, then a clean run.
    go(4, 1, 1);
    tick();
    repeat (3) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    cmp("T4 abort state", 64'(g_state), 64'd4);
    cmp("T4 err_src", 64'(g_err), 64'h10);
    go(4, 1, 1);
    cmp("T4 start ignored", 64'(g_state), 64'd4);
    clr = 1'b1; tick(); clr = 1'b0;
    go(4, 1, 1);
    tick();
    tlast = 4'hf; tick(); tlast = '0;
    tick();
    cmp("T4 done", 64'(g_done), 64'd1);

    // T5: reset mid-run clears the sticky mask.
    go(4, 1, 1);
    tick();
    tlast = 4'b0011; tick(); tlast = '0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    cmp("T5 state", 64'(g_state), 64'd0);
    cmp("T5 addr_max", 64'(g_addr), 64'd0);
    cmp("T5 run_cycles", 64'(g_cyc), 64'd0);
    go(4, 1, 1);
    tick();
    tlast = 4'b1100; tick(); tlast = '0;
    cmp("T5 still ope", 64'(g_state), 64'd2);
    tlast = 4'b0011; tick(); tlast = '0;
    cmp("T5 end", 64'(g_state), 64'd3);
    tick();

    // Saturation of run_cycles.
    tlimit = '0;
    go(4, 1, 1);
    tick();
    repeat (260) tick();
    cmp("sat run_cycles", 64'(g_cyc), 64'(CycMax));
    abort = 1'b1; tick(); abort = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;

`ifdef MCU_GLO_TIMEOUT_EN
    // T6: watchdog fires when run_cycles reaches the limit.
    tlimit = 8'd10;
    go(4, 1, 1);
    tick();
    repeat (11) tick();
    cmp("T6 state", 64'(g_state), 64'd4);
    cmp("T6 err_src", 64'(g_err), 64'h40);
    clr = 1'b1; tick(); clr = 1'b0;
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 149) == 0);
      clr   = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < NL; b++) tlast[b] = ($urandom_range(0, 7) == 0);
      lerr = ($urandom_range(0, 199) == 0) ? NL'($urandom_range(1, 15)) : '0;
      cfg_addr  = ($urandom_range(0, 9) == 0) ? '0 : (AW+1)'($urandom_range(1, 255));
      cfg_inter = ($urandom_range(0, 9) == 0) ? '0 : IEW'($urandom_range(1, 63));
      cfg_intra = ($urandom_range(0, 9) == 0) ? '0 : IAW'($urandom_range(1, 63));
      tlimit    = CW'($urandom_range(0, 40));
      tick();
    end
    start = 1'b0; abort = 1'b0; clr = 1'b0; rst = 1'b0; tlast = '0; lerr = '0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
